// File: rtl/dmem_arbiter_if.sv
// -----------------------------------------------------------------------------
// dmem_arbiter_if
// Request/response bundle for one requester of the shared data memory.
//
// Signals (direction seen from the requester, i.e. the master modport):
//   valid   out  request valid
//   ready   in   request accepted this cycle
//   we      out  1 = store, 0 = load
//   funct3  out  RV32 load/store funct3
//   addr    out  byte address
//   wdata   out  store data
//   rvalid  in   response valid, held until rready
//   rready  out  requester accepts the response
//   rdata   in   load data (0 for stores and errors)
//   err     in   response is an access error
// -----------------------------------------------------------------------------
interface dmem_arbiter_if #(
    parameter int ADDRESS_WIDTH = 32,
    parameter int DATA_WIDTH    = 32
);
    logic                     valid;
    logic                     ready;
    logic                     we;
    logic [2:0]               funct3;
    logic [ADDRESS_WIDTH-1:0] addr;
    logic [DATA_WIDTH-1:0]    wdata;
    logic                     rvalid;
    logic                     rready;
    logic [DATA_WIDTH-1:0]    rdata;
    logic                     err;

    // Requester side
    modport master (
        output valid, we, funct3, addr, wdata, rready,
        input  ready, rvalid, rdata, err
    );

    // Arbiter side
    modport slave (
        input  valid, we, funct3, addr, wdata, rready,
        output ready, rvalid, rdata, err
    );
endinterface

// File: rtl/dmem_arbiter.sv
// -----------------------------------------------------------------------------
// dmem_arbiter
// Shares one single-port data memory between two requesters. Port 0 is the
// pipeline memory stage, port 1 the loader/debug port. Round-robin grant, one
// memory access per cycle, a one-entry registered response buffer per port and
// trapping of misaligned/illegal accesses before they reach the memory.
//
// Ports:
//   clk            in   clock, rising edge
//   rst            in   asynchronous active-high reset
//   p0, p1         slave modports of dmem_arbiter_if (request + response)
//   mem_write_e    out  memory write enable
//   mem_funct3     out  funct3 forwarded to the memory
//   data_mem_addr  out  byte address forwarded to the memory
//   write_data_e   out  store data forwarded to the memory
//   read_data_m    in   asynchronous read data from the memory
//   err_count      out  saturating count of error responses issued
// -----------------------------------------------------------------------------
module dmem_arbiter #(
    parameter int ADDRESS_WIDTH = 32,
    parameter int DATA_WIDTH    = 32,
    parameter int ERR_CNT_WIDTH = 8
) (
    input  logic                     clk,
    input  logic                     rst,
    dmem_arbiter_if.slave            p0,
    dmem_arbiter_if.slave            p1,
    output logic                     mem_write_e,
    output logic [2:0]               mem_funct3,
    output logic [ADDRESS_WIDTH-1:0] data_mem_addr,
    output logic [DATA_WIDTH-1:0]    write_data_e,
    input  logic [DATA_WIDTH-1:0]    read_data_m,
    output logic [ERR_CNT_WIDTH-1:0] err_count
);

    typedef enum logic {
        PORT0 = 1'b0,
        PORT1 = 1'b1
    } port_e;

    port_e                     r_lastGrant;
    logic [1:0]                r_rvalid;
    logic [1:0]                r_err;
    logic [DATA_WIDTH-1:0]     r_rdata [2];
    logic [ERR_CNT_WIDTH-1:0]  r_errCount;

    logic [1:0]                w_valid;
    logic [1:0]                w_rready;
    logic [1:0]                w_elig;
    logic [1:0]                w_gnt;
    logic                      w_anyGrant;
    logic                      w_we;
    logic [2:0]                w_funct3;
    logic [ADDRESS_WIDTH-1:0]  w_addr;
    logic [DATA_WIDTH-1:0]     w_wdata;
    logic                      w_illegal;
    logic                      w_misaligned;
    logic                      w_err;

    assign w_valid  = {p1.valid,  p0.valid};
    assign w_rready = {p1.rready, p0.rready};

    // A port may issue only when its response slot is free or being drained
    // this same cycle; rready reaches the memory side only through this term.
    assign w_elig[0] = w_valid[0] && (!r_rvalid[0] || w_rready[0]);
    assign w_elig[1] = w_valid[1] && (!r_rvalid[1] || w_rready[1]);

    // On contention the port that did not win last time gets the grant.
    assign w_gnt[0]   = w_elig[0] && (!w_elig[1] || (r_lastGrant == PORT1));
    assign w_gnt[1]   = w_elig[1] && (!w_elig[0] || (r_lastGrant == PORT0));
    assign w_anyGrant = w_gnt[0] || w_gnt[1];

    assign p0.ready = w_gnt[0];
    assign p1.ready = w_gnt[1];

    // Selects the granted request; port 0 fields are the default so the mux
    // stays a simple 2:1 keyed on the port-1 grant.
    always_comb begin
        w_we     = p0.we;
        w_funct3 = p0.funct3;
        w_addr   = p0.addr;
        w_wdata  = p0.wdata;
        if (w_gnt[1]) begin
            w_we     = p1.we;
            w_funct3 = p1.funct3;
            w_addr   = p1.addr;
            w_wdata  = p1.wdata;
        end
    end

    // Illegal encodings: reserved funct3 values, plus the unsigned variants
    // which only exist for loads.
    assign w_illegal = (w_funct3 == 3'b011) || (w_funct3 == 3'b110) ||
                       (w_funct3 == 3'b111) ||
                       (w_we && ((w_funct3 == 3'b100) || (w_funct3 == 3'b101)));

    assign w_misaligned = ((w_funct3[1:0] == 2'b01) && w_addr[0]) ||
                          ((w_funct3 == 3'b010) && (w_addr[1:0] != 2'b00));

    assign w_err = w_illegal || w_misaligned;

    // Memory drive: idle values when nothing is granted, and no write at all
    // while reset is held or the access was trapped.
    always_comb begin
        mem_write_e   = 1'b0;
        mem_funct3    = 3'b010;
        data_mem_addr = '0;
        write_data_e  = '0;
        if (w_anyGrant) begin
            mem_write_e   = w_we && !w_err && !rst;
            mem_funct3    = w_funct3;
            data_mem_addr = w_addr;
            write_data_e  = w_wdata;
        end
    end

    // Response buffers, grant history and error counter. A grant reloads the
    // port's buffer even if it is being drained in the same cycle, which gives
    // back-to-back throughput of one access per cycle per port.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_lastGrant <= PORT1;
            r_rvalid    <= '0;
            r_err       <= '0;
            r_rdata[0]  <= '0;
            r_rdata[1]  <= '0;
            r_errCount  <= '0;
        end else begin
            if (w_anyGrant) begin
                r_lastGrant <= w_gnt[1] ? PORT1 : PORT0;
            end
            for (int n = 0; n < 2; n++) begin
                if (w_gnt[n]) begin
                    r_rvalid[n] <= 1'b1;
                    r_err[n]    <= w_err;
                    r_rdata[n]  <= (w_we || w_err) ? '0 : read_data_m;
                end else if (w_rready[n]) begin
                    r_rvalid[n] <= 1'b0;
                    r_err[n]    <= 1'b0;
                    r_rdata[n]  <= '0;
                end
            end
            if (w_anyGrant && w_err && (r_errCount != '1)) begin
                r_errCount <= r_errCount + ERR_CNT_WIDTH'(1);
            end
        end
    end

    assign p0.rvalid = r_rvalid[0];
    assign p0.err    = r_err[0];
    assign p0.rdata  = r_rdata[0];
    assign p1.rvalid = r_rvalid[1];
    assign p1.err    = r_err[1];
    assign p1.rdata  = r_rdata[1];
    assign err_count = r_errCount;

endmodule

// File: doc/dmem_arbiter.md
Name: dmem_arbiter

Overview:
- Shares the single-port data memory between two requesters with valid/ready handshakes.
- Port 0 is the pipeline memory stage; port 1 is the loader/debug port.
- Round-robin grant, at most one memory access per cycle.
- Per-port one-entry registered response buffer with backpressure; misaligned and illegal accesses are trapped before they reach memory.

Parameters:
- ADDRESS_WIDTH, 32, byte address width
- DATA_WIDTH, 32, data word width
- ERR_CNT_WIDTH, 8, width of saturating error counter

Ports:
- clk  in  1  clock, all state updates on rising edge
- rst  in  1  reset, asynchronous, active-high
- pN_valid  in  1  port N request valid (N = 0, 1; same set per port)
- pN_ready  out  1  port N request accepted this cycle (combinational)
- pN_we  in  1  1 = store, 0 = load
- pN_funct3  in  3  RV32 load/store funct3
- pN_addr  in  ADDRESS_WIDTH  byte address
- pN_wdata  in  DATA_WIDTH  store data
- pN_rvalid  out  1  response valid, held until pN_rready
- pN_rready  in  1  requester accepts response
- pN_rdata  out  DATA_WIDTH  load data (0 for stores/errors)
- pN_err  out  1  response is an access error
- mem_write_e  out  1  memory write enable
- mem_funct3  out  3  to memory funct3
- data_mem_addr  out  ADDRESS_WIDTH  to memory address
- write_data_e  out  DATA_WIDTH  to memory write data
- read_data_m  in  DATA_WIDTH  memory asynchronous read data
- err_count  out  ERR_CNT_WIDTH  saturating count of error responses issued

Behaviour:
- Reset values: pN_rvalid=0, pN_rdata=0, pN_err=0, err_count=0, last_grant=1 (port 0 wins the first contention). Reset mid-operation drops any buffered response; no memory write occurs while rst=1.
- Eligibility: port N is eligible iff pN_valid && (!pN_rvalid || pN_rready).
- Arbitration: if one port is eligible, grant it. If both are eligible, grant the port != last_grant. last_grant updates only on a grant.
- pN_ready = granted N, combinational, same cycle.
- Memory drive in the grant cycle: data_mem_addr, mem_funct3 and write_data_e come from the granted port. mem_write_e = we && !err.
- Memory drive with no grant: mem_write_e=0, data_mem_addr=0, mem_funct3=3'b010, write_data_e=0.
- Error detection (combinational on the granted request):
  - funct3 in {011,110,111}, or store with funct3 in {100,101}: illegal.
  - funct3[1:0]=01 with addr[0]=1: misaligned.
  - funct3=010 with addr[1:0]!=0: misaligned.
- Latency: an accept in cycle T gives pN_rvalid=1 from the edge ending T.
  - Loads: pN_rdata = read_data_m sampled at T.
  - Stores and errors: pN_rdata = 0.
  - pN_err = err.
- Response buffer: holds while pN_rvalid && !pN_rready. Clears on pN_rready unless a new accept for that port occurs in the same cycle, in which case it reloads (back-to-back, 1 access/cycle/port).
- Store-then-load to the same address from different ports in consecutive cycles returns the new data; the write completes at the edge ending cycle T.
- err_count: +1 per accepted error request (+2 is impossible since only one grant per cycle); saturates at all-ones.
- No combinational path from pN_rready to the memory-side outputs other than through eligibility.

Test Plan:
- Memory word 0 = 0x8000_00FF; p0 lw addr 0 -> p0_ready same cycle; next cycle p0_rvalid=1, p0_rdata=0x8000_00FF, p0_err=0.
- p0 and p1 both request loads for 4 cycles with rready=1 -> grants P0,P1,P0,P1; each port gets 2 responses.
- p1 load with p1_rready=0 for 3 cycles, p1_valid held -> p1_ready=0 while rvalid is held, p1_rdata stable, p0 still served; the new grant comes in the cycle p1_rready=1.
- p0 sw addr 0x6 data 0x1234_5678 -> mem_write_e=0, p0_err=1, p0_rdata=0, err_count=1, memory unchanged.
- p1 sb addr 0x5 data 0xAB, then p0 lbu addr 0x5 -> mem_funct3=000 on the write; p0_rdata=0x0000_00AB.
- p0 load accepted, rst pulsed asynchronously before p0_rready -> p0_rvalid=0 immediately, err_count=0, next contention grants port 0.
